// File: rtl/tinyrv_pkg.sv
// Shared definitions for the tinyrv multi-cycle core: opcodes, FSM states, field positions.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tinyrv_pkg;

    // RiSC-16 opcode map
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Instruction field positions
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int RA_MSB    = 12;
    localparam int RA_LSB    = 10;
    localparam int RB_MSB    = 9;
    localparam int RB_LSB    = 7;
    localparam int RC_MSB    = 2;
    localparam int RC_LSB    = 0;
    localparam int IMM7_MSB  = 6;
    localparam int IMM10_MSB = 9;

    // Ops that write rA at the end of EXEC (LW writes later, in MEM)
    function automatic logic writes_ra_in_exec(input logic [2:0] op, input logic imm_zero);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_NAND) ||
               (op == OP_LUI) || ((op == OP_JALR) && imm_zero);
    endfunction

endpackage

// File: rtl/tinyrv_mc_core_if.sv
// Instruction and data memory valid/ready bus of the tinyrv core.
// Latency: none; ready completes a request in the same cycle, read data valid with ready.
// Backpressure: requester holds valid and request fields stable until ready.
interface tinyrv_mc_core_if #(
    parameter int XLEN = 16,
    parameter int PC_W = 16
);
    logic            imem_valid;
    logic            imem_ready;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            dmem_valid;
    logic            dmem_ready;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output imem_valid, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_valid, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_valid, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_valid, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/tinyrv_regfile.sv
// 8-entry register file, r0 hardwired to zero; 2 combinational reads, 1 synchronous write.
// Latency: reads combinational, write visible the cycle after we.
// Backpressure: none; a write is always accepted. TINYRV_DBG_EN adds a third read port.
module tinyrv_regfile #(
    parameter int XLEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [2:0]      ra2,
    output logic [XLEN-1:0] rd2,
`ifdef TINYRV_DBG_EN
    input  logic [2:0]      ra3,
    output logic [XLEN-1:0] rd3,
`endif
    input  logic            we,
    input  logic [2:0]      wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] regs [0:7];

    // Register storage: clear on reset, never write r0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 3'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 3'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 3'd0) ? '0 : regs[ra2];
`ifdef TINYRV_DBG_EN
    assign rd3 = (ra3 == 3'd0) ? '0 : regs[ra3];
`endif

endmodule

// File: rtl/tinyrv_mc_core.sv
// Multi-cycle RiSC-16-style core (fetch FSM, ALU, PC, regfile); optional TINYRV_DBG_EN debug ports.
// Latency: ALU/branch/jump 2 cycles, LW/SW 3 cycles at zero wait; each wait cycle adds 1.
// Backpressure: imem/dmem requests held stable until ready; outputs are registered only.
module tinyrv_mc_core
    import tinyrv_pkg::*;
#(
    parameter int XLEN     = 16,
    parameter int PC_W     = 16,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    tinyrv_mc_core_if.master bus,
    output logic            halt
`ifdef TINYRV_DBG_EN
    ,
    input  logic [2:0]      dbg_sel,
    output logic [XLEN-1:0] dbg_data,
    output logic [PC_W-1:0] dbg_pc
`endif
);
    localparam logic [PC_W-1:0] START_PC = PC_W'(RESET_PC);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
    logic            imem_valid;
    logic            dmem_valid;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;

    // Decoded fields of the latched instruction
    logic [2:0]      op, ra, rb, rc;
    logic            imm_zero;
    logic [XLEN-1:0] simm;
    logic [PC_W-1:0] br_off;
    logic [XLEN-1:0] lui_val;

    assign op       = instr[OP_MSB:OP_LSB];
    assign ra       = instr[RA_MSB:RA_LSB];
    assign rb       = instr[RB_MSB:RB_LSB];
    assign rc       = instr[RC_MSB:RC_LSB];
    assign imm_zero = (instr[IMM7_MSB:0] == 7'd0);
    assign simm     = {{(XLEN-7){instr[IMM7_MSB]}}, instr[IMM7_MSB:0]};
    assign br_off   = {{(PC_W-7){instr[IMM7_MSB]}}, instr[IMM7_MSB:0]};
    assign lui_val  = {instr[IMM10_MSB:0], {(XLEN-10){1'b0}}};

    // Port 1 always reads rB; port 2 reads rC for register-register ops, rA otherwise
    logic [2:0]      rf_ra2;
    logic [XLEN-1:0] rs_b, rs_2;
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;
    logic [XLEN-1:0] alu_res;
    logic [PC_W-1:0] pc_inc;

    assign rf_ra2 = ((op == OP_ADD) || (op == OP_NAND)) ? rc : ra;
    assign pc_inc = pc + PC_W'(1);

    tinyrv_regfile #(.XLEN(XLEN)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rb),
        .rd1 (rs_b),
        .ra2 (rf_ra2),
        .rd2 (rs_2),
`ifdef TINYRV_DBG_EN
        .ra3 (dbg_sel),
        .rd3 (dbg_data),
`endif
        .we  (rf_we),
        .wa  (ra),
        .wd  (rf_wd)
    );

    // ALU result for ops that write rA in EXEC (JALR writes the zero-extended link)
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rs_b + rs_2;
            OP_ADDI: alu_res = rs_b + simm;
            OP_NAND: alu_res = ~(rs_b & rs_2);
            OP_LUI:  alu_res = lui_val;
            OP_JALR: alu_res = XLEN'(pc_inc);
            default: alu_res = '0;
        endcase
    end

    // Load data is written on the completing dmem handshake; ALU results in EXEC
    assign rf_we = ((state == ST_EXEC) && writes_ra_in_exec(op, imm_zero)) ||
                   ((state == ST_MEM) && bus.dmem_ready && !dmem_we);
    assign rf_wd = (state == ST_MEM) ? bus.dmem_rdata : alu_res;

    // Control FSM with registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BOOT;
            pc         <= START_PC;
            instr      <= '0;
            imem_valid <= 1'b0;
            dmem_valid <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halt       <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state      <= ST_FETCH;
                    imem_valid <= 1'b1;
                end
                ST_FETCH: begin
                    if (bus.imem_ready) begin
                        instr      <= bus.imem_rdata;
                        imem_valid <= 1'b0;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op)
                        OP_SW, OP_LW: begin
                            dmem_valid <= 1'b1;
                            dmem_we    <= (op == OP_SW);
                            dmem_addr  <= rs_b + simm;
                            dmem_wdata <= (op == OP_SW) ? rs_2 : '0;
                            pc         <= pc_inc;
                            state      <= ST_MEM;
                        end
                        OP_BEQ: begin
                            pc         <= (rs_b == rs_2) ? (pc_inc + br_off) : pc_inc;
                            imem_valid <= 1'b1;
                            state      <= ST_FETCH;
                        end
                        OP_JALR: begin
                            if (imm_zero) begin
                                // Target uses rB as read this cycle, before the link write
                                pc         <= PC_W'(rs_b);
                                imem_valid <= 1'b1;
                                state      <= ST_FETCH;
                            end else begin
                                halt  <= 1'b1;
                                state <= ST_HALT;
                            end
                        end
                        default: begin
                            pc         <= pc_inc;
                            imem_valid <= 1'b1;
                            state      <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        dmem_valid <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        imem_valid <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.imem_valid = imem_valid;
    assign bus.imem_addr  = pc;
    assign bus.dmem_valid = dmem_valid;
    assign bus.dmem_we    = dmem_we;
    assign bus.dmem_addr  = dmem_addr;
    assign bus.dmem_wdata = dmem_wdata;

`ifdef TINYRV_DBG_EN
    assign dbg_pc = pc;
`endif

endmodule

// File: tb/tb_tinyrv_mc_core.sv
// Testbench for tinyrv_mc_core: directed program plus random instruction stream vs an ISA-level model.
// Latency: every bus cycle is checked, so retire timing is checked cycle by cycle.
// Backpressure: random imem/dmem wait states driven by the bench.
module tb_tinyrv_mc_core;
    localparam int XLEN     = 16;
    localparam int PC_W     = 16;
    localparam int RESET_PC = 0;

    localparam logic [2:0] I_ADD = 3'd0, I_ADDI = 3'd1, I_NAND = 3'd2, I_LUI = 3'd3;
    localparam logic [2:0] I_SW  = 3'd4, I_LW   = 3'd5, I_BEQ  = 3'd6, I_JALR = 3'd7;

    logic clk = 1'b0;
    logic rst;
    logic halt;
    logic rst32;
    logic halt32;

    always #5 clk = ~clk;

    tinyrv_mc_core_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();
    tinyrv_mc_core_if #(.XLEN(32), .PC_W(PC_W)) bus32 ();

`ifdef TINYRV_DBG_EN
    logic [2:0]      dbg_sel = 3'd0;
    logic [XLEN-1:0] dbg_data;
    logic [PC_W-1:0] dbg_pc;
    logic [2:0]      dbg_sel32 = 3'd0;
    logic [31:0]     dbg_data32;
    logic [PC_W-1:0] dbg_pc32;
`endif

    tinyrv_mc_core #(.XLEN(XLEN), .PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .halt (halt)
`ifdef TINYRV_DBG_EN
        ,
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .dbg_pc   (dbg_pc)
`endif
    );

    // Second core at XLEN=32 running a fixed tiny program with zero-wait memory
    tinyrv_mc_core #(.XLEN(32), .PC_W(PC_W), .RESET_PC(0)) dut32 (
        .clk  (clk),
        .rst  (rst32),
        .bus  (bus32),
        .halt (halt32)
`ifdef TINYRV_DBG_EN
        ,
        .dbg_sel  (dbg_sel32),
        .dbg_data (dbg_data32),
        .dbg_pc   (dbg_pc32)
`endif
    );

    logic [15:0] prog32 [0:3];
    assign bus32.imem_ready = 1'b1;
    assign bus32.imem_rdata = prog32[bus32.imem_addr[1:0]];
    assign bus32.dmem_ready = 1'b1;
    assign bus32.dmem_rdata = '0;

    // ISA-level reference state
    logic [15:0]     m_reg [0:7];
    logic [PC_W-1:0] m_pc;
    logic [15:0]     m_mem [int];
    logic [31:0]     obs_wdata;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sx7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

    function automatic logic [15:0] enc_rrr(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction

    function automatic logic [15:0] enc_rri(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [6:0] imm);
        return {op, a, b, imm};
    endfunction

    task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
        if (r != 3'd0) m_reg[r] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_pc = PC_W'(RESET_PC);
    endtask

    // Serve one instruction: fetch with iw waits, exec, optional mem with dw waits.
    // abort_mem raises rst in the first MEM cycle instead of completing the access.
    task automatic exec_one(input logic [15:0] ins, input int iw, input int dw, input bit abort_mem);
        logic [2:0]  op, a, b, c;
        logic [15:0] s, ea, wd, rdata, tgt;
        bit          is_mem, is_st, do_halt;
        op = ins[15:13]; a = ins[12:10]; b = ins[9:7]; c = ins[2:0];
        s = sx7(ins[6:0]);
        is_mem = 0; is_st = 0; do_halt = 0; ea = '0; wd = '0; rdata = '0;
        for (int k = 0; k <= iw; k++) begin
            @(negedge clk);
            check("fetch_valid", 32'(bus.imem_valid), 32'd1);
            check("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
            check("fetch_dvalid", 32'(bus.dmem_valid), 32'd0);
`ifdef TINYRV_DBG_EN
            check("dbg_pc", 32'(dbg_pc), 32'(m_pc));
            check("dbg_r0", 32'(dbg_data), 32'd0);
`endif
            bus.dmem_ready = 1'b0;
            bus.imem_ready = (k == iw);
            bus.imem_rdata = (k == iw) ? ins : 16'($urandom);
        end
        @(negedge clk);
        check("exec_quiet", 32'({bus.imem_valid, bus.dmem_valid, bus.dmem_we, halt}), 32'd0);
        bus.imem_ready = 1'b0;
        case (op)
            I_ADD:  begin set_reg(a, m_reg[b] + m_reg[c]);    m_pc = m_pc + 16'd1; end
            I_ADDI: begin set_reg(a, m_reg[b] + s);           m_pc = m_pc + 16'd1; end
            I_NAND: begin set_reg(a, ~(m_reg[b] & m_reg[c])); m_pc = m_pc + 16'd1; end
            I_LUI:  begin set_reg(a, {ins[9:0], 6'b0});       m_pc = m_pc + 16'd1; end
            I_SW, I_LW: begin
                is_mem = 1; is_st = (op == I_SW);
                ea = m_reg[b] + s;
                wd = is_st ? m_reg[a] : 16'h0000;
                rdata = m_mem.exists(int'(ea)) ? m_mem[int'(ea)] : 16'($urandom);
                m_pc = m_pc + 16'd1;
            end
            I_BEQ: m_pc = (m_reg[a] == m_reg[b]) ? (m_pc + 16'd1 + s) : (m_pc + 16'd1);
            default: begin
                if (ins[6:0] == 7'd0) begin
                    tgt = m_reg[b];
                    set_reg(a, m_pc + 16'd1);
                    m_pc = tgt;
                end else begin
                    do_halt = 1;
                end
            end
        endcase
        if (is_mem) begin
            for (int k = 0; k <= dw; k++) begin
                @(negedge clk);
                check("mem_valid", 32'(bus.dmem_valid), 32'd1);
                check("mem_addr", 32'(bus.dmem_addr), 32'(ea));
                check("mem_we", 32'(bus.dmem_we), 32'(is_st));
                check("mem_wdata", 32'(bus.dmem_wdata), 32'(wd));
                check("mem_ivalid", 32'(bus.imem_valid), 32'd0);
                obs_wdata = 32'(bus.dmem_wdata);
                if (abort_mem) begin
                    bus.dmem_ready = 1'b0;
                    rst = 1'b1;
                    return;
                end
                bus.dmem_ready = (k == dw);
                bus.dmem_rdata = (k == dw) ? rdata : 16'($urandom);
            end
            if (is_st) m_mem[int'(ea)] = wd;
            else       set_reg(a, rdata);
        end
        if (do_halt) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                check("halt_flag", 32'(halt), 32'd1);
                check("halt_quiet", 32'({bus.imem_valid, bus.dmem_valid}), 32'd0);
            end
        end
    endtask

    task automatic run(input logic [15:0] ins);
        exec_one(ins, 0, 0, 0);
    endtask

    // Store rN to address 0 and compare the store data with a fixed value
    task automatic sw_check(input string tag, input logic [2:0] r, input logic [31:0] exp);
        exec_one(enc_rri(I_SW, r, 3'd0, 7'd0), 0, 0, 0);
        check(tag, obs_wdata, exp);
    endtask

    // Address of the fetch following the instruction just served
    task automatic peek_fetch(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check(tag, 32'(bus.imem_addr), exp);
    endtask

    initial begin
        logic [15:0] ins;
        bit found;
        rst = 1'b1;
        rst32 = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        prog32[0] = {I_LUI, 3'd4, 10'h3FF};
        prog32[1] = enc_rri(I_SW, 3'd4, 3'd0, 7'd0);
        prog32[2] = enc_rri(I_JALR, 3'd0, 3'd0, 7'd1);
        prog32[3] = 16'h0000;
        model_reset();

        // Reset / BOOT outputs
        repeat (2) @(negedge clk);
        check("rst_ivalid", 32'(bus.imem_valid), 32'd0);
        check("rst_dvalid", 32'(bus.dmem_valid), 32'd0);
        check("rst_we", 32'(bus.dmem_we), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_iaddr", 32'(bus.imem_addr), 32'(RESET_PC));
        check("rst_daddr", 32'(bus.dmem_addr), 32'd0);
        check("rst_wdata", 32'(bus.dmem_wdata), 32'd0);
        rst = 1'b0;

        // ALU basics
        run(enc_rri(I_ADDI, 3'd1, 3'd0, 7'd5));
        run(enc_rrr(I_ADD, 3'd2, 3'd1, 3'd1));
        run(enc_rrr(I_NAND, 3'd3, 3'd2, 3'd2));
        sw_check("add_r2", 3'd2, 32'h000A);
        sw_check("nand_r3", 3'd3, 32'hFFF5);
        run({I_LUI, 3'd4, 10'h3FF});
        sw_check("lui_r4", 3'd4, 32'hFFC0);

        // Memory with 3 wait cycles
        exec_one(enc_rri(I_SW, 3'd1, 3'd0, 7'd3), 0, 3, 0);
        check("sw_wait_wdata", obs_wdata, 32'd5);
        exec_one(enc_rri(I_LW, 3'd5, 3'd0, 7'd3), 0, 3, 0);
        sw_check("lw_r5", 3'd5, 32'd5);

        // Branches
        run(enc_rri(I_ADDI, 3'd6, 3'd0, 7'd16));
        run(enc_rri(I_JALR, 3'd7, 3'd6, 7'd0));
        peek_fetch("jalr_to_10", 32'h10);
        run(enc_rri(I_BEQ, 3'd1, 3'd1, 7'h7E));
        peek_fetch("beq_taken", 32'h0F);
        run(enc_rri(I_JALR, 3'd7, 3'd6, 7'd0));
        run(enc_rri(I_BEQ, 3'd1, 3'd2, 7'd5));
        peek_fetch("beq_not_taken", 32'h11);
        run(enc_rri(I_ADDI, 3'd0, 3'd0, 7'd7));
        sw_check("r0_zero", 3'd0, 32'd0);

        // JALR link
        run(enc_rri(I_ADDI, 3'd2, 3'd0, 7'd32));
        run(enc_rri(I_ADDI, 3'd7, 3'd0, 7'd4));
        run(enc_rri(I_JALR, 3'd0, 3'd7, 7'd0));
        peek_fetch("jalr_to_4", 32'h4);
        run(enc_rri(I_JALR, 3'd6, 3'd2, 7'd0));
        peek_fetch("jalr_to_20", 32'h20);
        sw_check("jalr_link_r6", 3'd6, 32'd5);
        run(enc_rri(I_ADDI, 3'd3, 3'd0, 7'd40));
        run(enc_rri(I_JALR, 3'd3, 3'd3, 7'd0));
        peek_fetch("jalr_same_reg", 32'd40);

        // Random instruction stream with random wait states
        for (int n = 0; n < 200; n++) begin
            ins = 16'($urandom);
            if (ins[15:13] == I_JALR) ins[6:0] = 7'd0;
            if ((ins[15:13] == I_SW || ins[15:13] == I_LW) && ($urandom_range(0, 1) == 1)) begin
                ins[9:7] = 3'd0;
                ins[6:0] = 7'($urandom_range(0, 15));
            end
            exec_one(ins, $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
        for (int r = 1; r < 8; r++) exec_one(enc_rri(I_SW, 3'(r), 3'd0, 7'(r)), 0, 1, 0);

        // Reset while a store is waiting
        run(enc_rri(I_ADDI, 3'd1, 3'd0, 7'd9));
        exec_one(enc_rri(I_SW, 3'd1, 3'd0, 7'd2), 0, 2, 1);
        @(negedge clk);
        check("abort_dvalid", 32'(bus.dmem_valid), 32'd0);
        check("abort_ivalid", 32'(bus.imem_valid), 32'd0);
        check("abort_iaddr", 32'(bus.imem_addr), 32'(RESET_PC));
        rst = 1'b0;
        model_reset();
        peek_fetch("boot_fetch", 32'(RESET_PC));
        sw_check("rst_r1", 3'd1, 32'd0);
        sw_check("rst_r2", 3'd2, 32'd0);
        sw_check("rst_r3", 3'd3, 32'd0);
        sw_check("rst_r4", 3'd4, 32'd0);
        sw_check("rst_r5", 3'd5, 32'd0);
        sw_check("rst_r6", 3'd6, 32'd0);
        sw_check("rst_r7", 3'd7, 32'd0);

        // Halt
        exec_one(enc_rri(I_JALR, 3'd0, 3'd0, 7'd1), 0, 0, 0);

        // LUI at XLEN=32
        @(negedge clk);
        rst32 = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus32.dmem_valid && bus32.dmem_we) found = 1;
        end
        check("x32_store_seen", 32'(found), 32'd1);
        check("x32_lui_r4", bus32.dmem_wdata, 32'hFFC00000);
        check("x32_addr", bus32.dmem_addr, 32'd0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (halt32) found = 1;
        end
        check("x32_halt", 32'(found), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
